// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch responder.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam int unsigned WAIT_CNT_W        = 4;

  function automatic int unsigned word_idx_w(input int unsigned depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction word store: one write port, one synchronous read port with a
// registered output that only changes when a read is enabled.
module imem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IDX_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [31:0]      wr_data_i,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [31:0]      rd_data_o
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_idx_i] <= wr_data_i;
  end

  // A write on the same edge as a read returns the previous contents.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)       rd_data_o <= '0;
    else if (rd_en_i) rd_data_o <= mem[rd_idx_i];
  end

endmodule

// File: rtl/imem_fetch_responder.sv
// Fetch-side instruction memory responder with configurable wait states.
// Optional IMEM_ALIGN_CHECK_EN adds misalign_o and NOPs misaligned fetches.
module imem_fetch_responder
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] NOP_INSTR   = NOP_INSTR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        flush_i,
  input  logic        load_en_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i,
  output logic [31:0] instr_o,
  output logic        valid_o,
`ifdef IMEM_ALIGN_CHECK_EN
  output logic        misalign_o,
`endif
  output logic        stall_o
);

  localparam int unsigned IDX_W  = word_idx_w(DEPTH_WORDS);
  localparam int unsigned HI_LSB = IDX_W + 2;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LD = WAIT_CNT_W'(WAIT_CYCLES);

  state_t                state;
  logic [WAIT_CNT_W-1:0] cnt;
  logic [31:0]           addr_q;
  logic                  valid_q;
  logic                  nop_q;
  logic                  accept;
  logic                  go_resp;
  logic [31:0]           rd_addr;
  logic                  rd_in_range;
  logic                  ld_in_range;
  logic                  nop_sel;
  logic [31:0]           rd_data;
  logic                  unused_bits;

  assign accept  = start_i & req_i & ~flush_i;
  assign go_resp = ((state == IDLE) & accept & (WAIT_CYCLES == 0)) |
                   ((state == WAIT) & ~flush_i & (cnt == WAIT_CNT_W'(1)));

  // With zero wait states the array is read straight from addr_i on the accept edge.
  assign rd_addr     = (state == IDLE) ? addr_i : addr_q;
  assign rd_in_range = (rd_addr[31:HI_LSB] == '0);
  assign ld_in_range = (load_addr_i[31:HI_LSB] == '0);
  assign unused_bits = ^{load_addr_i[1:0], rd_addr[1:0]};

`ifdef IMEM_ALIGN_CHECK_EN
  logic misalign_q;
  logic misaligned;
  assign misaligned = (rd_addr[1:0] != 2'b00);
  assign nop_sel    = ~rd_in_range | misaligned;
  assign misalign_o = misalign_q & ~flush_i;
`else
  assign nop_sel = ~rd_in_range;
`endif

  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_en_i  (load_en_i & ld_in_range),
    .wr_idx_i (load_addr_i[HI_LSB-1:2]),
    .wr_data_i(load_data_i),
    .rd_en_i  (go_resp),
    .rd_idx_i (rd_addr[HI_LSB-1:2]),
    .rd_data_o(rd_data)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      nop_q      <= 1'b0;
`ifdef IMEM_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      valid_q <= go_resp;
      if (go_resp) nop_q <= nop_sel;
`ifdef IMEM_ALIGN_CHECK_EN
      misalign_q <= go_resp & misaligned;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q <= addr_i;
            cnt    <= WAIT_LD;
            state  <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (flush_i) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == WAIT_CNT_W'(1)) state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Registered data and NOP select together form the held instruction.
  assign instr_o = nop_q ? NOP_INSTR : rd_data;
  assign valid_o = valid_q & ~flush_i;
  assign stall_o = rst_i & (((state == IDLE) & accept) | ((state == WAIT) & ~flush_i));

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench: a zero-wait-state instance driven from a vector table and a
// two-wait-state instance driven by hand sequences; both share load and reset.
module tb_imem_fetch_responder;

  localparam logic [31:0] NOP0 = 32'h0000_0013;
  localparam logic [31:0] W0   = 32'h1000_0000;
  localparam logic [31:0] W1   = 32'h1000_0001;
  localparam logic [31:0] W2   = 32'h1000_0002;
  localparam logic [31:0] W3   = 32'h2002_0005;
  localparam logic [31:0] W4   = 32'h1000_0004;
  localparam logic [31:0] W4N  = 32'hAAAA_0004;
`ifdef IMEM_ALIGN_CHECK_EN
  localparam logic [31:0] MIS_EXP = NOP0;
`else
  localparam logic [31:0] MIS_EXP = W1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_en;
  logic [31:0] ld_addr, ld_data;

  logic        start0, req0, flush0;
  logic [31:0] addr0, instr0;
  logic        valid0, stall0;
  logic        start2, req2, flush2;
  logic [31:0] addr2, instr2;
  logic        valid2, stall2;
`ifdef IMEM_ALIGN_CHECK_EN
  logic        mis0, mis2;
`endif

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clk = ~clk;

  imem_fetch_responder #(
    .DEPTH_WORDS(256),
    .WAIT_CYCLES(0),
    .NOP_INSTR  (NOP0)
  ) u_w0 (
    .clk_i(clk), .rst_i(rst), .start_i(start0), .req_i(req0), .addr_i(addr0),
    .flush_i(flush0), .load_en_i(ld_en), .load_addr_i(ld_addr), .load_data_i(ld_data),
    .instr_o(instr0), .valid_o(valid0),
`ifdef IMEM_ALIGN_CHECK_EN
    .misalign_o(mis0),
`endif
    .stall_o(stall0)
  );

  imem_fetch_responder #(
    .DEPTH_WORDS(256),
    .WAIT_CYCLES(2),
    .NOP_INSTR  (NOP0)
  ) u_w2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .req_i(req2), .addr_i(addr2),
    .flush_i(flush2), .load_en_i(ld_en), .load_addr_i(ld_addr), .load_data_i(ld_data),
    .instr_o(instr2), .valid_o(valid2),
`ifdef IMEM_ALIGN_CHECK_EN
    .misalign_o(mis2),
`endif
    .stall_o(stall2)
  );

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        flush;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        exp_stall;
    logic        exp_valid;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc2(input string tag, input logic s, input logic r, input logic [31:0] a,
                      input logic f, input logic e_st, input logic e_v, input logic [31:0] e_i);
    @(negedge clk);
    start2 = s; req2 = r; addr2 = a; flush2 = f;
    #1;
    chk({tag, " stall"}, {31'd0, stall2}, {31'd0, e_st});
    chk({tag, " valid"}, {31'd0, valid2}, {31'd0, e_v});
    chk({tag, " instr"}, instr2, e_i);
`ifdef IMEM_ALIGN_CHECK_EN
    chk({tag, " misalign"}, {31'd0, mis2}, 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    start0 = 1'b0; req0 = 1'b0; addr0 = '0; flush0 = 1'b0;
    start2 = 1'b0; req2 = 1'b0; addr2 = '0; flush2 = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("reset instr", instr2, 32'd0);
    chk("reset valid", {31'd0, valid2}, 32'd0);
    chk("reset stall", {31'd0, stall0}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_addr = 32'(k) * 4;
      ld_data = (k == 3) ? W3 : (W0 + 32'(k));
    end
    @(negedge clk);
    ld_en = 1'b0;

    //          req  addr          fl   ld   ld_addr        ld_data        st   v    instr
    vecs.push_back('{1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, W0});
    vecs.push_back('{1'b1, 32'h0000_0004, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, W0});
    vecs.push_back('{1'b1, 32'h0000_0004, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, W1});
    vecs.push_back('{1'b1, 32'h0000_0400, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, W1});
    vecs.push_back('{1'b1, 32'h0000_0400, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, NOP0});
    vecs.push_back('{1'b1, 32'h0000_0008, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, NOP0});
    vecs.push_back('{1'b1, 32'h0000_0008, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, W2});
    vecs.push_back('{1'b1, 32'h0000_000C, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, W2});
    vecs.push_back('{1'b0, 32'h0000_000C, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, W2});
    vecs.push_back('{1'b1, 32'h0000_0006, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, W2});
    vecs.push_back('{1'b1, 32'h0000_0006, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, MIS_EXP});
    vecs.push_back('{1'b1, 32'h0000_0010, 1'b0, 1'b1, 32'h10, W4N, 1'b1, 1'b0, MIS_EXP});
    vecs.push_back('{1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, W4});
    vecs.push_back('{1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, W4});
    vecs.push_back('{1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, W4N});
    vecs.push_back('{1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'h400, 32'hDEAD_BEEF, 1'b0, 1'b0, W4N});
    vecs.push_back('{1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, W4N});
    vecs.push_back('{1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, W0});

    start0 = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      req0 = vecs[i].req; addr0 = vecs[i].addr; flush0 = vecs[i].flush;
      ld_en = vecs[i].ld_en; ld_addr = vecs[i].ld_addr; ld_data = vecs[i].ld_data;
      #1;
      chk($sformatf("vec%0d stall", i), {31'd0, stall0}, {31'd0, vecs[i].exp_stall});
      chk($sformatf("vec%0d valid", i), {31'd0, valid0}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d instr", i), instr0, vecs[i].exp_instr);
`ifdef IMEM_ALIGN_CHECK_EN
      chk($sformatf("vec%0d misalign", i), {31'd0, mis0}, {31'd0, (i == 11)});
`endif
    end
    @(negedge clk);
    req0 = 1'b0; ld_en = 1'b0; start0 = 1'b0; flush0 = 1'b0;

    // Two wait states: stall through cycles 0-2, response in cycle 3.
    cyc2("lat c0", 1'b1, 1'b1, 32'h0C, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc2("lat c1", 1'b1, 1'b1, 32'h0C, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc2("lat c2", 1'b1, 1'b1, 32'h0C, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc2("lat c3", 1'b1, 1'b1, 32'h0C, 1'b0, 1'b0, 1'b1, W3);
    cyc2("lat c4", 1'b1, 1'b0, 32'h0C, 1'b0, 1'b0, 1'b0, W3);

    // Flush during WAIT drops the fetch.
    cyc2("fw c0", 1'b1, 1'b1, 32'h00, 1'b0, 1'b1, 1'b0, W3);
    cyc2("fw c1", 1'b1, 1'b1, 32'h00, 1'b1, 1'b0, 1'b0, W3);
    cyc2("fw c2", 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, W3);
    cyc2("fw c3", 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, W3);
    cyc2("fw c4", 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, W3);

    // start_i falling mid-fetch still completes.
    cyc2("st c0", 1'b1, 1'b1, 32'h04, 1'b0, 1'b1, 1'b0, W3);
    cyc2("st c1", 1'b0, 1'b0, 32'h04, 1'b0, 1'b1, 1'b0, W3);
    cyc2("st c2", 1'b0, 1'b0, 32'h04, 1'b0, 1'b1, 1'b0, W3);
    cyc2("st c3", 1'b0, 1'b0, 32'h04, 1'b0, 1'b0, 1'b1, W1);

    // Reset asserted mid-WAIT aborts with no response.
    cyc2("rs c0", 1'b1, 1'b1, 32'h08, 1'b0, 1'b1, 1'b0, W1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rs during stall", {31'd0, stall2}, 32'd0);
    chk("rs during valid", {31'd0, valid2}, 32'd0);
    chk("rs during instr", instr2, 32'd0);
    chk("rs during instr w0", instr0, 32'd0);
    @(negedge clk);
    rst = 1'b1; req2 = 1'b0;
    for (int j = 0; j < 4; j++) begin
      cyc2($sformatf("rs after%0d", j), 1'b1, 1'b0, 32'h08, 1'b0, 1'b0, 1'b0, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
